// File: rtl/seg7_scan_decoder.sv
// Recovers hex digits from a multiplexed seven-segment scan (hex/dp/an loopback).
// Define SEG7_DEC_ERRCNT_EN to build the saturating illegal-glyph counter.
module seg7_scan_decoder #(
    parameter int DIGITS        = 8,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          hex_i,
    input  logic                dp_i,
    input  logic [DIGITS-1:0]   an_i,
    output logic [4*DIGITS-1:0] digits_o,
    output logic [DIGITS-1:0]   dp_o,
    output logic [DIGITS-1:0]   valid_o,
    output logic                frame_o,
    output logic                err_o,
    output logic [7:0]          err_cnt_o,
    output logic [1:0]          state_o
);

    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [8:0] SETTLE_W = 9'(SETTLE_CYCLES);

    typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, HOLD = 2'd2} state_t;

    state_t              state;
    logic [6:0]          hex_s, ref_hex;
    logic                dp_s, ref_dp;
    logic [DIGITS-1:0]   an_s, ref_an;
    logic [7:0]          cnt;
    logic [DIGITS-1:0]   seen;
    logic [4*DIGITS-1:0] sh_dig;
    logic [DIGITS-1:0]   sh_dp, sh_val;

    logic [DIGITS-1:0]   low;
    logic                one_low;
    logic [IDXW-1:0]     idx;
    logic [3:0]          nib;
    logic                nib_ok;
    logic                match, an_changed, load, cap;
    logic [8:0]          cnt_next;
    logic [DIGITS-1:0]   cap_bit;

    always_comb begin
        nib    = 4'h0;
        nib_ok = 1'b1;
        case (hex_s)
            7'h40: nib = 4'h0;
            7'h79: nib = 4'h1;
            7'h24: nib = 4'h2;
            7'h30: nib = 4'h3;
            7'h19: nib = 4'h4;
            7'h12: nib = 4'h5;
            7'h02: nib = 4'h6;
            7'h78: nib = 4'h7;
            7'h00: nib = 4'h8;
            7'h10: nib = 4'h9;
            7'h08: nib = 4'hA;
            7'h03: nib = 4'hB;
            7'h46: nib = 4'hC;
            7'h21: nib = 4'hD;
            7'h06: nib = 4'hE;
            7'h0E: nib = 4'hF;
            default: nib_ok = 1'b0;
        endcase
    end

    // Exactly one active-low anode; blanking and ghosting both fail this test.
    always_comb begin
        low     = ~an_s;
        one_low = (low != '0) && ((low & (low - DIGITS'(1))) == '0);
        idx     = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (low[k]) idx = IDXW'(k);
        end
    end

    assign match      = (hex_s == ref_hex) && (dp_s == ref_dp) && (an_s == ref_an);
    assign an_changed = (an_s != ref_an);
    assign cnt_next   = {1'b0, cnt} + 9'd1;
    assign load       = one_low && ((state == IDLE) ||
                                    (state == HOLD && an_changed) ||
                                    (state == SETTLE && !match));
    // load counts as the first stable sample, so a one-cycle settle captures immediately.
    assign cap        = (load && (SETTLE_CYCLES == 1)) ||
                        (state == SETTLE && match && cnt_next >= SETTLE_W);
    assign cap_bit    = DIGITS'(1) << idx;
    assign state_o    = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            hex_s    <= '0;
            dp_s     <= 1'b1;
            an_s     <= '1;
            ref_hex  <= '0;
            ref_dp   <= 1'b1;
            ref_an   <= '1;
            cnt      <= '0;
            seen     <= '0;
            sh_dig   <= '0;
            sh_dp    <= '0;
            sh_val   <= '0;
            digits_o <= '0;
            dp_o     <= '0;
            valid_o  <= '0;
            frame_o  <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            hex_s   <= hex_i;
            dp_s    <= dp_i;
            an_s    <= an_i;
            frame_o <= 1'b0;
            err_o   <= 1'b0;

            if (load) begin
                ref_hex <= hex_s;
                ref_dp  <= dp_s;
                ref_an  <= an_s;
                cnt     <= 8'd1;
                state   <= cap ? HOLD : SETTLE;
            end else begin
                case (state)
                    IDLE: cnt <= '0;
                    SETTLE: begin
                        if (!match) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else if (cap) begin
                            state <= HOLD;
                        end else begin
                            cnt <= cnt_next[7:0];
                        end
                    end
                    HOLD: begin
                        if (an_changed) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end

            if (cap) begin
                sh_dig[4*idx +: 4] <= nib;
                sh_dp[idx]         <= ~dp_s;
                sh_val[idx]        <= nib_ok;
                err_o              <= ~nib_ok;
            end

            // Publish reads the shadow before this cycle's capture lands in it.
            if (&seen) begin
                digits_o <= sh_dig;
                dp_o     <= sh_dp;
                valid_o  <= sh_val;
                frame_o  <= 1'b1;
                seen     <= cap ? cap_bit : '0;
            end else if (cap) begin
                seen <= seen | cap_bit;
            end
        end
    end

`ifdef SEG7_DEC_ERRCNT_EN
    logic [7:0] err_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt <= '0;
        end else if (err_o && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    assign err_cnt_o = err_cnt;
`else
    assign err_cnt_o = '0;
`endif

endmodule
